// File: rtl/seg7_pkg.sv
// Shared constants and scan-state encoding for the 7-segment scan controller.
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic       ANODE_OFF = 1'b1;

  typedef enum logic {GAP = 1'b0, SHOW = 1'b1} scan_state_e;
endpackage

// File: rtl/seg7_scan_ctrl_dec.sv
// BCD digit decoder: 4-bit code to active-low {g,f,e,d,c,b,a}; A-F show a dash.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with double-buffered BCD word, frame-aligned
// commit, dead-time gaps between digits and optional leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK_GAP  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  input  logic [NUM_DIGITS-1:0]     load_blank,
  input  logic                      lz_suppress,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic [6:0]                display,
  output logic                      frame_done
);
  localparam int CW = $clog2(PRESCALE + BLANK_GAP + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam scan_state_e START = (BLANK_GAP == 0) ? SHOW : GAP;

  scan_state_e                 state, state_n;
  logic [CW-1:0]               cnt, cnt_n;
  logic [IW-1:0]               idx, idx_n;
  logic                        frame_end;

  logic [NUM_DIGITS-1:0][3:0]  pend_data, pend_data_n, act_data, act_data_n;
  logic [NUM_DIGITS-1:0]       pend_blank, pend_blank_n, act_blank, act_blank_n;
  logic                        pend_lz, pend_lz_n, pend_vld, pend_vld_n;
  logic [NUM_DIGITS-1:0]       lz_mask;
  logic                        allz;

  logic [3:0]                  sel;
  logic [6:0]                  seg_raw, disp_n;
  logic [NUM_DIGITS-1:0]       en_n;

  assign load_ready = !pend_vld;

  // Digit i>0 goes dark when it and every more-significant nibble are zero.
  always_comb begin
    lz_mask = '0;
    allz    = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      allz       = allz & (pend_data[i] == 4'h0);
      lz_mask[i] = pend_lz & allz;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt + 1'b1;
    idx_n        = idx;
    frame_end    = 1'b0;
    act_data_n   = act_data;
    act_blank_n  = act_blank;
    pend_data_n  = pend_data;
    pend_blank_n = pend_blank;
    pend_lz_n    = pend_lz;
    pend_vld_n   = pend_vld;
    case (state)
      GAP: if (cnt == CW'(BLANK_GAP - 1)) begin
        state_n = SHOW;
        cnt_n   = '0;
      end
      SHOW: if (cnt == CW'(PRESCALE - 1)) begin
        state_n = START;
        cnt_n   = '0;
        if (idx == IW'(NUM_DIGITS - 1)) begin
          idx_n     = '0;
          frame_end = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      default: state_n = START;
    endcase
    if (frame_end && pend_vld) begin
      act_data_n  = pend_data;
      act_blank_n = pend_blank | lz_mask;
      pend_vld_n  = 1'b0;
    end
    // Acceptance is gated by the pre-edge ready, so a commit and a new load
    // on the same edge never collide.
    if (load_valid && !pend_vld) begin
      pend_data_n  = load_data;
      pend_blank_n = load_blank;
      pend_lz_n    = lz_suppress;
      pend_vld_n   = 1'b1;
    end
  end

  // Outputs are computed from the next state so they land on the entering edge.
  always_comb sel = act_data_n[idx_n];

  seg7_dec u_dec (.code(sel), .seg(seg_raw));

  always_comb begin
    en_n   = {NUM_DIGITS{ANODE_OFF}};
    disp_n = SEG_BLANK;
    if (state_n == SHOW) begin
      en_n[idx_n] = ~ANODE_OFF;
      if (!act_blank_n[idx_n]) disp_n = seg_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= START;
      cnt        <= '0;
      idx        <= '0;
      pend_data  <= '0;
      pend_blank <= '0;
      pend_lz    <= 1'b0;
      pend_vld   <= 1'b0;
      act_data   <= '0;
      act_blank  <= '1;
      digit_en   <= {NUM_DIGITS{ANODE_OFF}};
      display    <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      pend_data  <= pend_data_n;
      pend_blank <= pend_blank_n;
      pend_lz    <= pend_lz_n;
      pend_vld   <= pend_vld_n;
      act_data   <= act_data_n;
      act_blank  <= act_blank_n;
      digit_en   <= en_n;
      display    <= disp_n;
      frame_done <= frame_end;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position reference model checked every cycle,
// directed scenarios with literal segment patterns, then randomized loads/resets.
module tb_seg7_scan_ctrl;
  localparam int ND = 4, PS = 4, BG = 2;
  localparam int SLOT = PS + BG, FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  load_blank = '0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  digit_en;
  logic [6:0]  display;
  logic        frame_done;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLANK_GAP(BG)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_blank(load_blank), .lz_suppress(lz_suppress),
    .digit_en(digit_en), .display(display), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  bit chk_on = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model: t = cycles since reset; frame position follows from t alone.
  int         t;
  bit         mpv;
  logic [3:0] pd [ND];
  logic [3:0] ad [ND];
  logic [3:0] pb, ab;
  bit         plz;

  always @(posedge clk) begin
    bit acc, z;
    if (rst) begin
      t = 0; mpv = 0; ab = 4'hF;
      for (int i = 0; i < ND; i++) ad[i] = 4'h0;
    end else begin
      acc = load_valid && !mpv;
      if ((t % FRAME) == FRAME - 1 && mpv) begin
        for (int i = 0; i < ND; i++) ad[i] = pd[i];
        ab = pb;
        for (int i = 1; i < ND; i++) begin
          z = 1;
          for (int j = i; j < ND; j++) if (pd[j] != 4'h0) z = 0;
          if (plz && z) ab[i] = 1'b1;
        end
        mpv = 0;
      end
      if (acc) begin
        for (int i = 0; i < ND; i++) pd[i] = load_data[4*i +: 4];
        pb = load_blank; plz = lz_suppress; mpv = 1;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    int p, s;
    logic [3:0] een;
    logic [6:0] edisp;
    logic [12:0] exp_v, act_v;
    if (chk_on) begin
      p = t % FRAME; s = p / SLOT;
      een = 4'hF; edisp = 7'h7F;
      if ((p % SLOT) >= BG) begin
        een[s] = 1'b0;
        if (!ab[s]) edisp = seg_of(ad[s]);
      end
      exp_v = {(t > 0 && p == 0), !mpv, een, edisp};
      act_v = {frame_done, load_ready, digit_en, display};
      chk(act_v === exp_v, "model{fd,rdy,en,disp}", 32'(act_v), 32'(exp_v));
    end
  end

  task automatic load(input logic [15:0] d, input logic [3:0] b, input logic lz);
    bit acc = 0;
    int n = 0;
    load_valid = 1; load_data = d; load_blank = b; lz_suppress = lz;
    while (!acc && n < 200) begin
      @(negedge clk); acc = load_ready;
      @(posedge clk); #1; n++;
    end
    load_valid = 0;
    if (!acc) chk(0, "load_timeout", 32'(n), 32'(200));
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 100);
    if (frame_done !== 1'b1) chk(0, "frame_done_timeout", 32'(n), 32'(100));
  endtask

  task automatic show_check(input logic [3:0] en, input logic [6:0] exp, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (digit_en !== en && n < 100);
    if (digit_en !== en) chk(0, {nm, "_anode_timeout"}, 32'(digit_en), 32'(en));
    else chk(display === exp, nm, 32'(display), 32'(exp));
  endtask

  initial begin
    logic [3:0] en_log [49];
    int fd_cnt, seen8, n;
    repeat (2) @(posedge clk);
    #1 rst = 0; chk_on = 1;

    // Idle frames: dark display, anode walk, frame_done cadence.
    fd_cnt = 0;
    for (int k = 0; k < 49; k++) begin
      @(negedge clk);
      en_log[k] = digit_en;
      if (frame_done) fd_cnt++;
      if (k == 0) chk(load_ready === 1'b1 && display === 7'h7F, "reset_state", 32'({load_ready, display}), 32'({1'b1, 7'h7F}));
    end
    chk(fd_cnt == 2, "idle_fd_count", 32'(fd_cnt), 32'(2));
    chk(en_log[1] === 4'b1111 && en_log[2] === 4'b1110 && en_log[8] === 4'b1101 && en_log[23] === 4'b0111,
        "idle_anode_walk", 32'({en_log[1], en_log[2], en_log[8], en_log[23]}), 32'(16'hFED7));

    // Plain BCD word.
    load(16'h1234, 4'b0000, 1'b0);
    wait_fd();
    show_check(4'b1110, 7'b0011001, "d0_is_4");
    show_check(4'b1101, 7'b0110000, "d1_is_3");
    show_check(4'b1011, 7'b0100100, "d2_is_2");
    show_check(4'b0111, 7'b1111001, "d3_is_1");

    // Back-to-back words: B waits for A's commit.
    load(16'h5678, 4'b0000, 1'b0);
    chk(load_ready === 1'b0, "ready_low_after_A", 32'(load_ready), 32'(0));
    load(16'h9012, 4'b0000, 1'b0);
    show_check(4'b1110, 7'b0000000, "A_d0_is_8");
    wait_fd();
    show_check(4'b1110, 7'b0100100, "B_d0_is_2");

    // Leading-zero suppression.
    load(16'h0070, 4'b0000, 1'b1);
    wait_fd();
    show_check(4'b1110, 7'b1000000, "lz_d0_is_0");
    show_check(4'b1101, 7'b1111000, "lz_d1_is_7");
    show_check(4'b1011, 7'b1111111, "lz_d2_dark");
    show_check(4'b0111, 7'b1111111, "lz_d3_dark");
    load(16'h0000, 4'b0000, 1'b1);
    wait_fd();
    show_check(4'b1110, 7'b1000000, "allz_d0_is_0");
    show_check(4'b1101, 7'b1111111, "allz_d1_dark");
    show_check(4'b0111, 7'b1111111, "allz_d3_dark");

    // Dash codes plus explicit blank.
    load(16'hB0F5, 4'b0010, 1'b0);
    wait_fd();
    show_check(4'b1110, 7'b0010010, "mix_d0_is_5");
    show_check(4'b1101, 7'b1111111, "mix_d1_blanked");
    show_check(4'b1011, 7'b1000000, "mix_d2_is_0");
    show_check(4'b0111, 7'b0111111, "mix_d3_dash");

    // Reset mid-SHOW discards the pending word.
    wait_fd();
    load(16'h8888, 4'b0000, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (digit_en === 4'hF && n < 20);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk({digit_en, display, load_ready} === {4'hF, 7'h7F, 1'b1}, "post_rst_dark",
        32'({digit_en, display, load_ready}), 32'({4'hF, 7'h7F, 1'b1}));
    seen8 = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (display === 7'b0000000) seen8++;
    end
    chk(seen8 == 0, "discarded_word_hidden", 32'(seen8), 32'(0));

    // Randomized loads, blanks, lz and occasional resets.
    for (int k = 0; k < 2500; k++) begin
      logic [15:0] d;
      @(posedge clk); #1;
      d = 16'($urandom);
      for (int i = 3; i >= 0; i--) if ($urandom_range(0, 1) == 0) d[4*i +: 4] = 4'h0;
      rst         = ($urandom_range(0, 399) == 0);
      load_valid  = ($urandom_range(0, 3) == 0);
      load_data   = d;
      load_blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lz_suppress = 1'($urandom);
    end
    @(posedge clk); #1 rst = 0; load_valid = 0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passes, checks);
    $fatal(1);
  end
endmodule
